// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
// display sharing one 4-bit-to-7-segment decoder. Each digit owns a slot of
// DIV cycles; the first DEAD cycles of every slot keep all selects off to
// suppress ghosting. New display words arrive over a valid/ready handshake
// and are held in a pending register until the next frame boundary.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load_valid   new display word offered
//   load_ready   controller can accept a word (no word pending)
//   load_data    digit i in bits [4i+3:4i], digit 0 least significant
//   lz_en        leading-zero suppression enable, sampled every cycle
//   digit_nibble nibble for the shared segment decoder (registered)
//   digit_sel_n  active-low digit select, one-hot-low or all ones (registered)
//   frame_done   one-cycle pulse on the last cycle of digit NDIG-1's slot

module seg_scan_ctrl #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 1000,
  parameter int unsigned DEAD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic              lz_en,
  output logic [3:0]        digit_nibble,
  output logic [NDIG-1:0]   digit_sel_n,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = $clog2(NDIG);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] active;
  logic [4*NDIG-1:0] pending;
  logic              pend_v;

  logic              slot_end;
  logic              wrap;
  logic              pre_wrap;
  logic [3:0]        act_nib [NDIG];
  logic [NDIG:1]     zero_from;   // zero_from[k]: digits k..NDIG-1 are all zero
  logic [NDIG-1:0]   supp;
  logic [NDIG-1:0]   sel_d;
  logic [3:0]        nib_d;

  assign load_ready = ~pend_v;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  // frame_done is registered yet must coincide with the wrap cycle itself,
  // so it is loaded one cycle early from the cycle preceding the wrap.
  assign pre_wrap = (cnt == CNT_PRE) && (idx == IDX_LAST);

  for (genvar g = 0; g < NDIG; g++) begin : g_nib
    assign act_nib[g] = active[4*g +: 4];
  end

  assign zero_from[NDIG] = (act_nib[NDIG-1] == 4'h0);
  for (genvar g = 1; g < NDIG; g++) begin : g_zero
    if (g < NDIG - 1) begin : g_chain
      assign zero_from[g] = (act_nib[g] == 4'h0) && zero_from[g+1];
    end else begin : g_top
      assign zero_from[g] = zero_from[NDIG];
    end
  end

  // Digit 0 is never blanked, so a value of zero still shows one '0'.
  assign supp = {zero_from[NDIG-1:1] & {(NDIG-1){lz_en}}, 1'b0};

  always_comb begin
    nib_d = act_nib[idx];
    sel_d = '1;
    if ((cnt >= CNT_DEAD) && !supp[idx]) begin
      sel_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pend_v       <= 1'b0;
      digit_nibble <= '0;
      digit_sel_n  <= '1;
      frame_done   <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Commit and accept never collide: a pending word blocks acceptance,
      // and a word accepted in the wrap cycle waits a full frame.
      if (wrap && pend_v) begin
        active <= pending;
        pend_v <= 1'b0;
      end else if (load_valid && !pend_v) begin
        pending <= load_data;
        pend_v  <= 1'b1;
      end

      digit_nibble <= nib_d;
      digit_sel_n  <= sel_d;
      frame_done   <= pre_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with NDIG=4, DIV=8, DEAD=2.
// p counts rising edges since reset release; outputs sampled after edge p
// reflect state t=p-1 (slot position (p-1)%8, digit ((p-1)/8)%4). A word
// accepted on edge pa is committed on the next edge that is a multiple of 32
// strictly after pa and is visible from the following edge on.

module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FRM  = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int p = 0;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .lz_en        (lz_en),
    .digit_nibble (digit_nibble),
    .digit_sel_n  (digit_sel_n),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_sel(input int pos, input int dig, input logic [3:0] supp);
    logic [3:0] mask;
    mask = 4'(1 << dig);
    if (pos >= DEAD && (supp & mask) == 4'h0) return ~mask;
    return 4'hF;
  endfunction

  function automatic logic [3:0] nib_of(input logic [15:0] w, input int dig);
    return 4'(w >> (4 * dig));
  endfunction

  task automatic step();
    @(posedge clk);
    p++;
    @(negedge clk);
  endtask

  task automatic go_to(input int t);
    while (p < t) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    checks++; if (digit_sel_n !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=f", digit_sel_n); end
    checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL reset_nib got=%h exp=0", digit_nibble); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
  endtask

  task automatic test_idle();
    int pos, dig;
    logic efd;
    while (p < 2 * FRM) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      efd = (p % FRM == FRM - 1);
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'h0)) begin errors++; $display("FAIL idle_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'h0)); end
      checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL idle_nib p=%0d got=%h exp=0", p, digit_nibble); end
      checks++; if (frame_done !== efd) begin errors++; $display("FAIL idle_fd p=%0d got=%b exp=%b", p, frame_done, efd); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_ready p=%0d got=%b exp=1", p, load_ready); end
    end
  endtask

  task automatic test_load_1234();
    int pos, dig;
    lz_en = 1'b0;
    load_valid = 1'b1;
    load_data = 16'h1234;
    step();                       // p=65, accepted
    load_valid = 1'b0;
    load_data = 16'hFFFF;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL l1234_ready_drop got=%b exp=0", load_ready); end
    while (p < 96) begin
      step();
      checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL l1234_hold p=%0d got=%h exp=0", p, digit_nibble); end
      checks++; if (load_ready !== (p >= 96)) begin errors++; $display("FAIL l1234_ready p=%0d got=%b exp=%b", p, load_ready, (p >= 96)); end
    end
    while (p < 128) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      checks++; if (digit_nibble !== nib_of(16'h1234, dig)) begin errors++; $display("FAIL l1234_nib p=%0d got=%h exp=%h", p, digit_nibble, nib_of(16'h1234, dig)); end
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'h0)) begin errors++; $display("FAIL l1234_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'h0)); end
    end
  endtask

  task automatic test_lz_0050();
    int pos, dig;
    load_valid = 1'b1;
    load_data = 16'h0050;
    lz_en = 1'b1;
    step();                       // p=129, accepted
    load_valid = 1'b0;
    go_to(160);
    while (p < 192) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      checks++; if (digit_nibble !== nib_of(16'h0050, dig)) begin errors++; $display("FAIL lz50_nib p=%0d got=%h exp=%h", p, digit_nibble, nib_of(16'h0050, dig)); end
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'b1100)) begin errors++; $display("FAIL lz50_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'b1100)); end
    end
    lz_en = 1'b0;
    while (p < 224) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'h0)) begin errors++; $display("FAIL nolz50_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'h0)); end
    end
  endtask

  task automatic test_zero_lz();
    int pos, dig;
    load_valid = 1'b1;
    load_data = 16'h0000;
    lz_en = 1'b1;
    step();                       // p=225, accepted
    load_valid = 1'b0;
    go_to(256);
    while (p < 288) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL lz0_nib p=%0d got=%h exp=0", p, digit_nibble); end
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'b1110)) begin errors++; $display("FAIL lz0_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'b1110)); end
    end
  endtask

  task automatic test_back_to_back();
    lz_en = 1'b0;
    load_valid = 1'b1;
    load_data = 16'hAAAA;
    step();                       // p=289, AAAA accepted
    load_data = 16'hBBBB;         // held valid while not ready
    while (p < 320) begin
      step();
      checks++; if (load_ready !== (p == 320)) begin errors++; $display("FAIL b2b_ready p=%0d got=%b exp=%b", p, load_ready, (p == 320)); end
    end
    step();                       // p=321, BBBB accepted
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_acc got=%b exp=0", load_ready); end
    checks++; if (digit_nibble !== 4'hA) begin errors++; $display("FAIL b2b_first_nib p=%0d got=%h exp=a", p, digit_nibble); end
    while (p < 352) begin
      step();
      checks++; if (digit_nibble !== 4'hA) begin errors++; $display("FAIL b2b_a p=%0d got=%h exp=a", p, digit_nibble); end
    end
    while (p < 383) begin
      step();
      checks++; if (digit_nibble !== 4'hB) begin errors++; $display("FAIL b2b_b p=%0d got=%h exp=b", p, digit_nibble); end
    end
    // p=383: the state now sitting in the register is the wrap cycle
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready_pre got=%b exp=1", load_ready); end
    load_valid = 1'b1;
    load_data = 16'hCCCC;
    step();                       // p=384, CCCC accepted into pending only
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready_post got=%b exp=0", load_ready); end
    checks++; if (digit_nibble !== 4'hB) begin errors++; $display("FAIL wrap_nib384 got=%h exp=b", digit_nibble); end
    while (p < 416) begin
      step();
      checks++; if (digit_nibble !== 4'hB) begin errors++; $display("FAIL wrap_b p=%0d got=%h exp=b", p, digit_nibble); end
    end
    while (p < 448) begin
      step();
      checks++; if (digit_nibble !== 4'hC) begin errors++; $display("FAIL wrap_c p=%0d got=%h exp=c", p, digit_nibble); end
    end
  endtask

  task automatic test_reset_mid();
    int pos, dig;
    load_valid = 1'b1;
    load_data = 16'h5678;
    step();                       // p=449, accepted
    load_valid = 1'b0;
    step();
    step();                       // p=451: digit 0, slot position 2
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rmid_pend got=%b exp=0", load_ready); end
    checks++; if (digit_sel_n !== 4'hE) begin errors++; $display("FAIL rmid_pre_sel got=%h exp=e", digit_sel_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (digit_sel_n !== 4'hF) begin errors++; $display("FAIL rmid_sel got=%h exp=f", digit_sel_n); end
    checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL rmid_nib got=%h exp=0", digit_nibble); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", load_ready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_fd got=%b exp=0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    while (p < 2 * FRM) begin
      step();
      pos = (p - 1) % DIV;
      dig = ((p - 1) / DIV) % NDIG;
      checks++; if (digit_nibble !== 4'h0) begin errors++; $display("FAIL rpost_nib p=%0d got=%h exp=0", p, digit_nibble); end
      checks++; if (digit_sel_n !== exp_sel(pos, dig, 4'h0)) begin errors++; $display("FAIL rpost_sel p=%0d got=%h exp=%h", p, digit_sel_n, exp_sel(pos, dig, 4'h0)); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rpost_ready p=%0d got=%b exp=1", p, load_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_1234();
    test_lz_0050();
    test_zero_lz();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
